craft_mc_serial: RTL and testbench
==================================

CRAFT_MC_SERIAL -- requirements
Module: craft_mc_serial

Interface
REQ-001 SHALL have parameter LANES, default 1, meaning columns processed per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter: CNT_W, default 16, meaning width of the statistics counter (REQ-030).
REQ-003 SHALL have port: clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  input state offered.
REQ-006 SHALL have port: in_ready  output  1  block can accept a state.
REQ-007 SHALL have port: in_state  input  64  CRAFT state; nibble I0 = bits [63:60], I15 = [3:0], row-major (row r = I4r..I4r+3).
REQ-008 SHALL have port: cm_en  input  2  bit0 enables row-0 update, bit1 enables row-1 update; sampled at acceptance.
REQ-009 SHALL have port: out_valid  output  1  result state available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: out_state  output  64  MixColumns result, same nibble order as in_state.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: in_ready=1; on in_valid=1, SHALL latch in_state and cm_en, clear column counter, and go to BUSY.
REQ-014 BUSY: each cycle SHALL transform LANES columns starting at the counter value, advance the counter by LANES, and go to DONE after the final group.
REQ-015 Per column j (a=I[j], b=I[j+4], c=I[j+8], d=I[j+12]): a' = cm_en[0] ? a^c^d : a; b' = cm_en[1] ? b^d : b; c, d unchanged.
REQ-016 SHALL process columns in ascending order 0..3; counter wraps to 0 after the final group.
REQ-017 Latency: out_valid SHALL rise exactly 4/LANES cycles after the acceptance edge (4, 2, 1 for LANES=1, 2, 4).
REQ-018 DONE: out_valid=1 and out_state stable until out_ready=1; on out_ready=1, SHALL go to IDLE.
REQ-019 in_ready SHALL be 0 in BUSY and DONE; in_valid there SHALL be ignored without side effects.
REQ-020 Acceptance and output handshake SHALL NOT occur in the same cycle; the next acceptance is earliest one cycle after out_ready.
REQ-021 out_ready while not in DONE SHALL have no effect.
REQ-022 in_state/cm_en changes after acceptance SHALL NOT affect the result in progress.
REQ-023 out_state SHALL be the registered working state; its value outside DONE is don't-care, but it SHALL NOT change while in DONE.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, column counter=0, working state=0.
REQ-025 Reset mid-BUSY or mid-DONE SHALL discard the operation; no out_valid pulse SHALL follow.
REQ-026 Reset SHALL dominate in_valid and out_ready in the same cycle.

Configuration
REQ-027 SHALL honour macro CRAFT_MC_STATS_EN.
REQ-028 With CRAFT_MC_STATS_EN defined: SHALL add output port blk_cnt  output  CNT_W  count of completed output handshakes.
REQ-029 blk_cnt SHALL reset to 0, increment by 1 on each cycle with out_valid&&out_ready, and wrap from all-ones to 0.
REQ-030 Without CRAFT_MC_STATS_EN: blk_cnt port and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 LANES=1, cm_en=2'b11, in_state=64'h0123456789ABCDEF -> out_valid 4 cycles after accept, out_state=64'h4567888889ABCDEF.
REQ-032 LANES=4, cm_en=2'b11, in_state=64'hFFFFFFFFFFFFFFFF -> out_valid 1 cycle after accept, out_state=64'hFFFF0000FFFFFFFF.
REQ-033 LANES=2, cm_en=2'b01, in_state=64'h0123456789ABCDEF -> after 2 cycles out_state=64'h456745678 9ABCDEF with spaces removed, i.e. 64'h4567456789ABCDEF; cm_en=2'b00 -> out_state equals in_state.
REQ-034 Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/in_state -> out_valid, out_state stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 Assert rst one cycle after acceptance (LANES=1) -> next cycle in_ready=1, out_valid=0, no later out_valid without a new acceptance.
REQ-036 CRAFT_MC_STATS_EN defined, CNT_W=2: 5 back-to-back blocks -> blk_cnt sequence 1,2,3,0,1; rst -> blk_cnt=0.

Source files
------------

// File: rtl/craft_mc_serial.sv
// ---------------------------------------------------------------------------
// craft_mc_serial -- column-serial CRAFT MixColumns engine.
//
// A 64-bit CRAFT state is accepted in IDLE, transformed LANES columns per
// cycle in BUSY, then held in DONE until the consumer takes it.
// Per column j (a=I[j], b=I[j+4], c=I[j+8], d=I[j+12]):
//   a' = cm_en[0] ? a^c^d : a ;  b' = cm_en[1] ? b^d : b ;  c, d unchanged.
//
// Parameters
//   LANES  columns processed per cycle (1, 2 or 4)
//   CNT_W  width of the optional completed-block counter
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input state offered
//   in_ready   block can accept a state (IDLE)
//   in_state   CRAFT state, nibble I0 = [63:60] .. I15 = [3:0], row-major
//   cm_en      bit0 enables row-0 update, bit1 enables row-1 update
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_state  result, same nibble order as in_state
//   blk_cnt    completed output handshakes (only with CRAFT_MC_STATS_EN)
//
// Optional feature macro: CRAFT_MC_STATS_EN adds blk_cnt and its counter.
// ---------------------------------------------------------------------------

// One column's MixColumns update; rows 2 and 3 pass through untouched.
module craft_mc_col (
  input  logic [1:0] en,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] c,
  input  logic [3:0] d,
  output logic [3:0] a_o,
  output logic [3:0] b_o
);
  assign a_o = en[0] ? (a ^ c ^ d) : a;
  assign b_o = en[1] ? (b ^ d)     : b;
endmodule

module craft_mc_serial #(
  parameter int LANES = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_state,
  input  logic [1:0]       cm_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_state
`ifdef CRAFT_MC_STATS_EN
  ,
  output logic [CNT_W-1:0] blk_cnt
`endif
);

  // Counter value that starts the final column group.
  localparam logic [1:0] LAST_COL = 2'(4 - LANES);
  localparam logic [1:0] COL_STEP = 2'(LANES);  // LANES=4 wraps to 0

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [1:0]       en_q, en_nxt;
  // Working state as nibbles; index 15 is I0 so the packing matches in_state.
  logic [15:0][3:0] st, st_nxt, st_xf;

  // Per-lane column index and nibble positions of rows 0..3.
  logic [LANES-1:0][1:0] col_l;
  logic [LANES-1:0][3:0] ia_l, ib_l, ic_l, id_l;
  logic [LANES-1:0][3:0] a_l, b_l, c_l, d_l, a_o, b_o;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign col_l[l] = cnt + 2'(l);
    assign ia_l[l]  = 4'd15 - {2'b00, col_l[l]};
    assign ib_l[l]  = 4'd11 - {2'b00, col_l[l]};
    assign ic_l[l]  = 4'd7  - {2'b00, col_l[l]};
    assign id_l[l]  = 4'd3  - {2'b00, col_l[l]};
    assign a_l[l]   = st[ia_l[l]];
    assign b_l[l]   = st[ib_l[l]];
    assign c_l[l]   = st[ic_l[l]];
    assign d_l[l]   = st[id_l[l]];

    craft_mc_col u_col (
      .en  (en_q),
      .a   (a_l[l]),
      .b   (b_l[l]),
      .c   (c_l[l]),
      .d   (d_l[l]),
      .a_o (a_o[l]),
      .b_o (b_o[l])
    );
  end

  // Merge this cycle's transformed columns back into the working state.
  always_comb begin
    st_xf = st;
    for (int l = 0; l < LANES; l++) begin
      st_xf[ia_l[l]] = a_o[l];
      st_xf[ib_l[l]] = b_o[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      en_q  <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      en_q  <= en_nxt;
      st    <= st_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    en_nxt    = en_q;
    st_nxt    = st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_nxt    = in_state;
          en_nxt    = cm_en;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        st_nxt  = st_xf;
        cnt_nxt = cnt + COL_STEP;
        if (cnt == LAST_COL) state_nxt = DONE;
      end
      DONE: begin
        // Working state is not written here, so out_state holds.
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_state = st;

`ifdef CRAFT_MC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                          blk_cnt <= '0;
    else if (out_valid && out_ready)  blk_cnt <= blk_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_craft_mc_serial.sv
// Directed bench: three instances (LANES=1,2,4) share inputs and are
// checked against hand-computed results, latencies and handshake rules.
module tb_craft_mc_serial;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [63:0] in_state;
  logic [1:0]  cm_en;
  logic        rdy1, rdy2, rdy4, vld1, vld2, vld4;
  logic [63:0] st1, st2, st4;
`ifdef CRAFT_MC_STATS_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt2, cnt4;
`endif
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  craft_mc_serial #(.LANES(1), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_state(in_state), .cm_en(cm_en), .out_valid(vld1),
    .out_ready(out_ready), .out_state(st1)
`ifdef CRAFT_MC_STATS_EN
    , .blk_cnt(cnt1)
`endif
  );
  craft_mc_serial #(.LANES(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .in_state(in_state), .cm_en(cm_en), .out_valid(vld2),
    .out_ready(out_ready), .out_state(st2)
`ifdef CRAFT_MC_STATS_EN
    , .blk_cnt(cnt2)
`endif
  );
  craft_mc_serial #(.LANES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_state(in_state), .cm_en(cm_en), .out_valid(vld4),
    .out_ready(out_ready), .out_state(st4)
`ifdef CRAFT_MC_STATS_EN
    , .blk_cnt(cnt4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_out(input string tag, input logic [63:0] exp);
    chk({tag, " L1"}, st1, exp);
    chk({tag, " L2"}, st2, exp);
    chk({tag, " L4"}, st4, exp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post-handshake in_ready", {rdy1, rdy2, rdy4}, 3'b111);
    chk("post-handshake out_valid", {vld1, vld2, vld4}, 3'b000);
  endtask

  task automatic accept(input logic [63:0] s, input logic [1:0] e);
    in_state = s;
    cm_en    = e;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_state = '0; cm_en = 2'b00;
    tick(); tick();
    chk("reset in_ready", {rdy1, rdy2, rdy4}, 3'b111);
    chk("reset out_valid", {vld1, vld2, vld4}, 3'b000);
    chk_all_out("reset state", 64'h0);
`ifdef CRAFT_MC_STATS_EN
    chk("reset blk_cnt", {62'd0, cnt1}, 64'd0);
`endif
    rst = 1'b0;

    // out_ready in IDLE does nothing
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("idle out_ready in_ready", {rdy1, rdy2, rdy4}, 3'b111);
    chk("idle out_ready out_valid", {vld1, vld2, vld4}, 3'b000);

    // Full MixColumns; inputs scrambled after acceptance must not matter.
    accept(64'h0123456789ABCDEF, 2'b11);
    in_state = 64'hA5A5_5A5A_0F0F_F0F0; cm_en = 2'b00;
    chk("busy in_ready", {rdy1, rdy2, rdy4}, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("latency c%0d", k), {vld1, vld2, vld4},
          {(k >= 4) ? 1'b1 : 1'b0, (k >= 2) ? 1'b1 : 1'b0, 1'b1});
    end
    chk_all_out("mc 11", 64'h4567888889ABCDEF);
    release_out();

    // All-ones, then stall in DONE for 10 cycles with input noise.
    accept(64'hFFFFFFFFFFFFFFFF, 2'b11);
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      in_state = 64'h1111_2222_3333_4444 * (k + 1);
      cm_en    = 2'(k);
      tick();
      chk($sformatf("stall vld c%0d", k), {vld1, vld2, vld4}, 3'b111);
      chk($sformatf("stall rdy c%0d", k), {rdy1, rdy2, rdy4}, 3'b000);
      chk($sformatf("stall st c%0d", k), st1, 64'hFFFF0000FFFFFFFF);
    end
    in_valid = 1'b0;
    chk_all_out("mc ones", 64'hFFFF0000FFFFFFFF);
    release_out();

    // Row-0 only, then no update at all.
    accept(64'h0123456789ABCDEF, 2'b01);
    repeat (4) tick();
    chk_all_out("mc 01", 64'h4567456789ABCDEF);
    release_out();
    accept(64'hDEADBEEF01234567, 2'b00);
    repeat (4) tick();
    chk_all_out("mc 00", 64'hDEADBEEF01234567);
    release_out();

    // Reset one cycle after acceptance, with in_valid held high.
    accept(64'h0123456789ABCDEF, 2'b11);
    rst = 1'b1; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst busy in_ready", {rdy1, rdy2, rdy4}, 3'b111);
    chk("rst busy out_valid", {vld1, vld2, vld4}, 3'b000);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("rst no vld c%0d", k), {vld1, vld2, vld4}, 3'b000);
    end

    // Reset in DONE dominates out_ready.
    accept(64'h0123456789ABCDEF, 2'b11);
    repeat (4) tick();
    chk("pre-rst done vld", {vld1, vld2, vld4}, 3'b111);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("rst done in_ready", {rdy1, rdy2, rdy4}, 3'b111);
    chk("rst done out_valid", {vld1, vld2, vld4}, 3'b000);
    chk_all_out("rst done state", 64'h0);

`ifdef CRAFT_MC_STATS_EN
    // Back-to-back blocks on the 2-bit counter: 1,2,3,0,1.
    chk("stats start", {62'd0, cnt1}, 64'd0);
    in_state = 64'h0123456789ABCDEF; cm_en = 2'b11;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int w = 0; w < 20 && !vld1; w++) tick();
      chk($sformatf("blk%0d wait vld1", b), {63'd0, vld1}, 64'd1);
      chk($sformatf("blk%0d out", b), st1, 64'h4567888889ABCDEF);
      tick();
      chk($sformatf("blk%0d blk_cnt", b), {62'd0, cnt1}, 64'((b + 1) % 4));
      chk($sformatf("blk%0d no overlap", b), {62'd0, rdy1, vld1}, 64'd2);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats rst", {62'd0, cnt1}, 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
